// File: rtl/si_ddr_req_gen.sv
// Packs TS byte bursts into 32-bit DDR write commands, queues read requests,
// and arbitrates both onto one registered valid/ready command port.
module si_ddr_req_gen #(
  parameter int unsigned WR_DEPTH = 16,
  parameter int unsigned RD_DEPTH = 4,
  parameter int unsigned WR_HI    = 12,
  parameter logic [7:0]  PAD_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  si_ddr_din,
  input  logic        si_ddr_din_en,
  input  logic [35:0] si_addr_din,
  input  logic        si_addr_din_en,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_wr,
  output logic [35:0] cmd_addr,
  output logic [31:0] cmd_wdata,
  output logic [15:0] wr_drop_cnt,
  output logic [15:0] rd_drop_cnt,
  output logic        busy
);

  localparam int unsigned WA = $clog2(WR_DEPTH);
  localparam int unsigned RA = $clog2(RD_DEPTH);

  typedef enum logic [1:0] {P_HDR0, P_HDR1, P_HDR2, P_PAY} pk_t;
  typedef enum logic {A_IDLE, A_ISSUE} arb_t;

  pk_t         r_pk;
  logic        r_resync, r_done, r_trunc;
  logic [9:0]  r_index;
  logic [3:0]  r_section;
  logic [31:0] r_word;
  logic [1:0]  r_lane;
  logic [7:0]  r_word_off;
  logic        r_push_vld;
  logic [35:0] r_push_addr;
  logic [31:0] r_push_data;

  logic [35:0] w_addr;
  logic [31:0] w_pad_data;
  logic [4:0]  w_lane_sh;
  logic        w_trunc_hit;

  assign w_addr    = {4'b0000, 1'b1, 9'b0, r_index, r_section, r_word_off};
  assign w_lane_sh = {~r_lane, 3'b000};
  assign w_trunc_hit = !r_resync && si_ddr_din_en && (r_pk == P_PAY) && r_done && !r_trunc;

  always_comb begin
    w_pad_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_pad_data[31-8*i -: 8] = (i < 32'(r_lane)) ? r_word[31-8*i -: 8] : PAD_BYTE;
    end
  end

  // Byte packer: header capture, big-endian lane fill, tail padding, 256-word cap.
  always_ff @(posedge clk) begin
    r_push_vld <= 1'b0;
    if (rst) begin
      r_pk        <= P_HDR0;
      r_resync    <= 1'b1;
      r_done      <= 1'b0;
      r_trunc     <= 1'b0;
      r_index     <= '0;
      r_section   <= '0;
      r_word      <= '0;
      r_lane      <= '0;
      r_word_off  <= '0;
      r_push_addr <= '0;
      r_push_data <= '0;
    end else if (r_resync) begin
      if (!si_ddr_din_en) r_resync <= 1'b0;
    end else if (si_ddr_din_en) begin
      unique case (r_pk)
        P_HDR0: begin
          r_index[9:8] <= si_ddr_din[1:0];
          r_pk         <= P_HDR1;
        end
        P_HDR1: begin
          r_index[7:0] <= si_ddr_din;
          r_pk         <= P_HDR2;
        end
        P_HDR2: begin
          r_section  <= si_ddr_din[3:0];
          r_lane     <= '0;
          r_word_off <= '0;
          r_done     <= 1'b0;
          r_trunc    <= 1'b0;
          r_pk       <= P_PAY;
        end
        default: begin
          if (r_done) begin
            r_trunc <= 1'b1;
          end else if (r_lane == 2'd3) begin
            r_push_vld  <= 1'b1;
            r_push_addr <= w_addr;
            r_push_data <= {r_word[31:8], si_ddr_din};
            r_lane      <= '0;
            r_word_off  <= r_word_off + 8'd1;
            if (r_word_off == '1) r_done <= 1'b1;
          end else begin
            r_word[w_lane_sh +: 8] <= si_ddr_din;
            r_lane                 <= r_lane + 2'd1;
          end
        end
      endcase
    end else begin
      if ((r_pk == P_PAY) && (r_lane != '0)) begin
        r_push_vld  <= 1'b1;
        r_push_addr <= w_addr;
        r_push_data <= w_pad_data;
        r_lane      <= '0;
      end
      r_pk <= P_HDR0;
    end
  end

  logic [67:0] r_wr_mem [WR_DEPTH];
  logic [WA-1:0] r_wr_wp, r_wr_rp;
  logic [WA:0]   r_wr_cnt;
  logic w_wr_full, w_wr_empty, w_wr_acc, w_wr_drop, w_wr_pop;

  logic [35:0] r_rd_mem [RD_DEPTH];
  logic [RA-1:0] r_rd_wp, r_rd_rp;
  logic [RA:0]   r_rd_cnt;
  logic w_rd_full, w_rd_empty, w_rd_acc, w_rd_drop, w_rd_pop;

  assign w_wr_full  = (r_wr_cnt == (WA+1)'(WR_DEPTH));
  assign w_wr_empty = (r_wr_cnt == '0);
  assign w_wr_acc   = r_push_vld && (!w_wr_full || w_wr_pop);
  assign w_wr_drop  = r_push_vld && !w_wr_acc;

  assign w_rd_full  = (r_rd_cnt == (RA+1)'(RD_DEPTH));
  assign w_rd_empty = (r_rd_cnt == '0);
  assign w_rd_acc   = si_addr_din_en && (!w_rd_full || w_rd_pop);
  assign w_rd_drop  = si_addr_din_en && !w_rd_acc;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_wr_mem[r_wr_wp] <= {r_push_addr, r_push_data};
    if (w_rd_acc) r_rd_mem[r_rd_wp] <= si_addr_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_wp <= '0; r_wr_rp <= '0; r_wr_cnt <= '0;
      r_rd_wp <= '0; r_rd_rp <= '0; r_rd_cnt <= '0;
    end else begin
      if (w_wr_acc) r_wr_wp <= r_wr_wp + 1'b1;
      if (w_wr_pop) r_wr_rp <= r_wr_rp + 1'b1;
      if (w_wr_acc && !w_wr_pop)      r_wr_cnt <= r_wr_cnt + 1'b1;
      else if (!w_wr_acc && w_wr_pop) r_wr_cnt <= r_wr_cnt - 1'b1;
      if (w_rd_acc) r_rd_wp <= r_rd_wp + 1'b1;
      if (w_rd_pop) r_rd_rp <= r_rd_rp + 1'b1;
      if (w_rd_acc && !w_rd_pop)      r_rd_cnt <= r_rd_cnt + 1'b1;
      else if (!w_rd_acc && w_rd_pop) r_rd_cnt <= r_rd_cnt - 1'b1;
    end
  end

  arb_t r_arb, w_arb_nxt;
  logic w_load;

  always_ff @(posedge clk) begin
    if (rst) r_arb <= A_IDLE;
    else     r_arb <= w_arb_nxt;
  end

  // Re-selection also happens on acceptance so commands can go back-to-back.
  always_comb begin
    w_arb_nxt = r_arb;
    w_wr_pop  = 1'b0;
    w_rd_pop  = 1'b0;
    w_load    = (r_arb == A_IDLE) || cmd_ready;
    if (w_load) begin
      if (!w_wr_empty && (r_wr_cnt >= (WA+1)'(WR_HI))) w_wr_pop = 1'b1;
      else if (!w_rd_empty)                            w_rd_pop = 1'b1;
      else if (!w_wr_empty)                            w_wr_pop = 1'b1;
      w_arb_nxt = (w_wr_pop || w_rd_pop) ? A_ISSUE : A_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (w_wr_pop) begin
      cmd_wr                <= 1'b1;
      {cmd_addr, cmd_wdata} <= r_wr_mem[r_wr_rp];
    end else if (w_rd_pop) begin
      cmd_wr    <= 1'b0;
      cmd_addr  <= r_rd_mem[r_rd_rp];
      cmd_wdata <= '0;
    end
  end

  assign cmd_valid = (r_arb == A_ISSUE);
  assign busy      = !w_wr_empty || !w_rd_empty || cmd_valid;

  // A FIFO-full drop and a truncation can land in the same cycle.
  logic [16:0] w_wr_sum;
  assign w_wr_sum = {1'b0, wr_drop_cnt} + 17'(w_wr_drop) + 17'(w_trunc_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_drop_cnt <= '0;
      rd_drop_cnt <= '0;
    end else begin
      wr_drop_cnt <= w_wr_sum[16] ? 16'hFFFF : w_wr_sum[15:0];
      if (w_rd_drop && (rd_drop_cnt != '1)) rd_drop_cnt <= rd_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_si_ddr_req_gen.sv
// Scoreboard bench for si_ddr_req_gen: expected commands are queued at stimulus
// time from a burst-level model; a monitor pops and compares on each acceptance.
module tb_si_ddr_req_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  si_ddr_din;
  logic        si_ddr_din_en;
  logic [35:0] si_addr_din;
  logic        si_addr_din_en;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [35:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [15:0] wr_drop_cnt, rd_drop_cnt;
  logic        busy;

  always #5 clk = ~clk;

  si_ddr_req_gen #(.WR_DEPTH(16), .RD_DEPTH(4), .WR_HI(12), .PAD_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .si_ddr_din(si_ddr_din), .si_ddr_din_en(si_ddr_din_en),
    .si_addr_din(si_addr_din), .si_addr_din_en(si_addr_din_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .wr_drop_cnt(wr_drop_cnt), .rd_drop_cnt(rd_drop_cnt), .busy(busy)
  );

  int unsigned n_cmp = 0, n_err = 0, n_cmds = 0;
  int unsigned m_wr_drop = 0, m_rd_drop = 0;
  logic [67:0] exp_wr[$];
  logic [35:0] exp_rd[$];
  logic [7:0]  burst_q[$];
  bit          log_q[$];
  bit          rnd_done;

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic        hold = 1'b0;
  logic [68:0] held;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("hold_stable", {cmd_valid, cmd_wr, cmd_addr, cmd_wdata}, {1'b1, held});
      if (cmd_valid && cmd_ready) begin
        n_cmds++;
        log_q.push_back(cmd_wr);
        if (cmd_wr) begin
          if (exp_wr.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL wr_unexpected: got %h/%h expected none", cmd_addr, cmd_wdata);
          end else chk("wr_cmd", 70'({cmd_addr, cmd_wdata}), 70'(exp_wr.pop_front()));
        end else begin
          if (exp_rd.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rd_unexpected: got %h expected none", cmd_addr);
          end else chk("rd_cmd", 70'({cmd_addr, cmd_wdata}), 70'({exp_rd.pop_front(), 32'h0}));
        end
      end
      hold = cmd_valid && !cmd_ready;
      held = {cmd_wr, cmd_addr, cmd_wdata};
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic make_burst(input logic [9:0] idx, input logic [3:0] sec, input int unsigned plen);
    logic [7:0] b;
    burst_q.delete();
    b = 8'($urandom); b[1:0] = idx[9:8]; burst_q.push_back(b);
    burst_q.push_back(idx[7:0]);
    b = 8'($urandom); b[3:0] = sec;      burst_q.push_back(b);
    for (int unsigned i = 0; i < plen; i++) burst_q.push_back(8'($urandom));
  endtask

  // Words are ceil(payload/4), tail padded with FF, capped at 256 per burst.
  task automatic model_burst();
    logic [7:0]  b0, b1, b2, bb;
    logic [9:0]  idx;
    logic [3:0]  sec;
    logic [31:0] data;
    int unsigned plen, nw, pos;
    if (burst_q.size() < 4) return;
    b0 = burst_q[0]; b1 = burst_q[1]; b2 = burst_q[2];
    idx  = {b0[1:0], b1};
    sec  = b2[3:0];
    plen = burst_q.size() - 3;
    nw   = (plen + 3) / 4;
    if (nw > 256) begin m_wr_drop++; nw = 256; end
    for (int unsigned w = 0; w < nw; w++) begin
      data = 0;
      for (int unsigned k = 0; k < 4; k++) begin
        pos  = 3 + 4*w + k;
        bb   = (pos < burst_q.size()) ? burst_q[pos] : 8'hFF;
        data = {data[23:0], bb};
      end
      exp_wr.push_back({4'h0, 1'b1, 9'h0, idx, sec, 8'(w), data});
    end
  endtask

  task automatic send_burst();
    foreach (burst_q[i]) begin
      tick(); si_ddr_din_en = 1'b1; si_ddr_din = burst_q[i];
    end
    tick(); si_ddr_din_en = 1'b0; si_ddr_din = '0;
  endtask

  task automatic read_pulse(input logic [35:0] a);
    tick(); si_addr_din_en = 1'b1; si_addr_din = a;
    tick(); si_addr_din_en = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || busy) && t < 3000) begin tick(); t++; end
    chk("drain_left", 70'(exp_wr.size() + exp_rd.size()), 70'(0));
    chk("drain_busy", 70'(busy), 70'(0));
  endtask

  task automatic chk_outs_zero();
    chk("rst_outs", {cmd_valid, cmd_wr, cmd_addr, cmd_wdata}, 70'(0));
    chk("rst_cnts", 70'({wr_drop_cnt, rd_drop_cnt, busy}), 70'(0));
  endtask

  initial begin
    int unsigned n0, t;
    logic [13:0] ord;
    rst = 1'b1; si_ddr_din = '0; si_ddr_din_en = 1'b0;
    si_addr_din = '0; si_addr_din_en = 1'b0; cmd_ready = 1'b1; rnd_done = 1'b0;
    repeat (3) tick();
    @(negedge clk); chk_outs_zero();
    tick(); rst = 1'b0; tick();

    // Known burst with literal expectations
    burst_q = {8'h00, 8'h05, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    exp_wr.push_back({36'h0_8000_5300, 32'hAABBCCDD});
    exp_wr.push_back({36'h0_8000_5301, 32'hEEFFFFFF});
    send_burst(); drain();
    chk("t1_wrdrop", 70'(wr_drop_cnt), 70'(0));

    // Header-only and shorter bursts produce nothing
    n0 = n_cmds;
    make_burst(10'h155, 4'h7, 0); model_burst(); send_burst();
    void'(burst_q.pop_back());    model_burst(); send_burst();
    repeat (20) tick();
    chk("t2_no_cmd", 70'(n_cmds), 70'(n0));
    chk("t2_wrdrop", 70'(wr_drop_cnt), 70'(0));

    // Overlong burst truncates at 256 words
    n0 = n_cmds;
    make_burst(10'h2C1, 4'hA, 1030); model_burst(); send_burst(); drain();
    chk("t3_words", 70'(n_cmds - n0), 70'(256));
    chk("t3_wrdrop", 70'(wr_drop_cnt), 70'(m_wr_drop));

    // Backpressure: 1 in output register + 16 queued, remaining 3 dropped
    cmd_ready = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      make_burst(10'(i + 32), 4'(i), 4); model_burst(); send_burst();
    end
    repeat (3) void'(exp_wr.pop_back());
    m_wr_drop += 3;
    repeat (5) tick();
    chk("t4_wrdrop", 70'(wr_drop_cnt), 70'(m_wr_drop));
    chk("t4_valid", 70'(cmd_valid), 70'(1));
    n0 = n_cmds;
    cmd_ready = 1'b1; drain();
    chk("t4_count", 70'(n_cmds - n0), 70'(17));

    // Reads: 6 pulses, 1 dropped; reads beat a lone write
    cmd_ready = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < 5) exp_rd.push_back(36'h8_8000_1200 + 36'(i) * 36'h100);
      else       m_rd_drop++;
      read_pulse(36'h8_8000_1200 + 36'(i) * 36'h100);
    end
    make_burst(10'h3A5, 4'hC, 4); model_burst(); send_burst();
    repeat (5) tick();
    chk("t5_rddrop", 70'(rd_drop_cnt), 70'(m_rd_drop));
    log_q.delete();
    cmd_ready = 1'b1; drain();
    ord = '0;
    foreach (log_q[i]) ord = {ord[12:0], log_q[i]};
    chk("t5_rd_first", 70'({4'(log_q.size()), ord}), 70'({4'd6, 14'b000001}));

    // Write FIFO at WR_HI: a write is chosen before the queued read
    cmd_ready = 1'b0;
    for (int unsigned i = 0; i < 13; i++) begin
      make_burst(10'(i + 100), 4'h5, 4); model_burst(); send_burst();
    end
    exp_rd.push_back(36'h8_8000_3400); read_pulse(36'h8_8000_3400);
    repeat (5) tick();
    log_q.delete();
    cmd_ready = 1'b1; drain();
    ord = '0;
    foreach (log_q[i]) ord = {ord[12:0], log_q[i]};
    chk("t5_wr_first", 70'({4'(log_q.size()), ord}), 70'({4'd14, 14'b11011111111111}));

    // Randomized traffic with random backpressure
    fork
      begin
        for (int unsigned b = 0; b < 60; b++) begin
          t = 0;
          while (exp_wr.size() > 4 && t < 1000) begin tick(); t++; end
          if (t >= 1000) begin
            n_cmp++; n_err++;
            $display("FAIL rnd_stall: got %0d pending expected <=4", exp_wr.size());
          end
          make_burst(10'($urandom), 4'($urandom), $urandom_range(0, 40));
          if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) void'(burst_q.pop_back());
          model_burst(); send_burst();
          repeat ($urandom_range(0, 3)) tick();
        end
        rnd_done = 1'b1;
      end
      begin
        logic [35:0] a;
        while (!rnd_done) begin
          tick();
          a = {4'($urandom), 1'b1, 9'h0, 10'($urandom), 4'($urandom), 8'h00};
          if ($urandom_range(0, 9) == 0 && exp_rd.size() < 4) begin
            exp_rd.push_back(a); si_addr_din = a; si_addr_din_en = 1'b1;
          end else si_addr_din_en = 1'b0;
        end
        si_addr_din_en = 1'b0;
      end
      begin
        while (!rnd_done) begin tick(); cmd_ready = ($urandom_range(0, 3) != 0); end
        cmd_ready = 1'b1;
      end
    join
    drain();
    chk("rnd_wrdrop", 70'(wr_drop_cnt), 70'(m_wr_drop));
    chk("rnd_rddrop", 70'(rd_drop_cnt), 70'(m_rd_drop));

    // Reset mid-burst; trailing bytes after release are ignored
    make_burst(10'h0F0, 4'h9, 8);
    for (int unsigned i = 0; i < 5; i++) begin tick(); si_ddr_din_en = 1'b1; si_ddr_din = burst_q[i]; end
    tick(); rst = 1'b1; si_ddr_din = burst_q[5];
    tick(); si_ddr_din = burst_q[6];
    @(negedge clk); chk_outs_zero();
    m_wr_drop = 0; m_rd_drop = 0;
    tick(); rst = 1'b0; si_ddr_din = burst_q[7];
    for (int unsigned i = 8; i < 11; i++) begin tick(); si_ddr_din = burst_q[i]; end
    tick(); si_ddr_din_en = 1'b0;
    n0 = n_cmds;
    repeat (20) tick();
    chk("t6_ignored", 70'(n_cmds), 70'(n0));
    make_burst(10'h1E3, 4'h2, 9); model_burst(); send_burst(); drain();
    chk("t6_words", 70'(n_cmds - n0), 70'(3));
    chk("t6_cnts", 70'({wr_drop_cnt, rd_drop_cnt}), 70'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
